// File: rtl/calc_result_display.sv
// calc_result_display: latches a 5-bit signed result and converts it to sign
// plus two BCD digits by sequential shift-add-3. The value is shown on a
// 4-digit common-anode 7-segment display, multiplexed one digit per slot.
module calc_result_display #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] result,
  input  logic       load,
  output logic       busy,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  // Glyphs are held lit-high internally; polarity is applied at the pins.
  localparam logic [6:0] GL_BLANK = 7'b0000000;
  localparam logic [6:0] GL_MINUS = 7'b1000000;
  localparam logic [6:0] SEG_POL  = {7{SEG_ACTIVE_LOW}};
  localparam logic [3:0] AN_POL   = {4{AN_ACTIVE_LOW}};

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t      state_q;
  logic        busy_q;
  logic        neg_q;
  logic [4:0]  mag_q;
  logic [7:0]  bcd_q;
  logic [2:0]  step_q;
  logic        pend_q;
  logic [4:0]  pend_val_q;
  logic [6:0]  disp0_q, disp1_q, disp2_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]  idx_q;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;

  logic [7:0]  bcd_adj;
  logic [7:0]  bcd_shift;
  logic [4:0]  start_val;
  logic [6:0]  g_sign, g_tens, g_ones;
  logic [6:0]  cur_glyph;

  function automatic logic [4:0] mag_of(input logic [4:0] r);
    // -16 negates to 5'b10000 = 16, which still fits unsigned in 5 bits.
    return r[4] ? 5'(~r + 5'd1) : r;
  endfunction

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return GL_BLANK;
    endcase
  endfunction

  // One double-dabble step: add 3 to nibbles >= 5, then shift in next magnitude bit.
  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    bcd_shift = (bcd_adj << 1) | {7'b0, mag_q[4]};
  end

  // Glyphs for the finished conversion and the value to restart from in DONE.
  always_comb begin
    g_sign    = (neg_q && (bcd_q != 8'd0)) ? GL_MINUS : GL_BLANK;
    g_tens    = (bcd_q[7:4] == 4'd0) ? GL_BLANK : digit_glyph(bcd_q[7:4]);
    g_ones    = digit_glyph(bcd_q[3:0]);
    // A load arriving in DONE is newer than any pending value, so it wins.
    start_val = load ? result : pend_val_q;
  end

  // Conversion FSM: capture, five shift-add-3 steps, then publish to display regs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      neg_q      <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      step_q     <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      disp0_q    <= digit_glyph(4'd0);
      disp1_q    <= GL_BLANK;
      disp2_q    <= GL_BLANK;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            neg_q   <= result[4];
            mag_q   <= mag_of(result);
            bcd_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          bcd_q  <= bcd_shift;
          mag_q  <= {mag_q[3:0], 1'b0};
          step_q <= step_q + 3'd1;
          if (step_q == 3'd4) state_q <= DONE;
          if (load) begin
            pend_q     <= 1'b1;
            pend_val_q <= result;
          end
        end
        DONE: begin
          disp0_q <= g_ones;
          disp1_q <= g_tens;
          disp2_q <= g_sign;
          if (load || pend_q) begin
            pend_q  <= 1'b0;
            neg_q   <= start_val[4];
            mag_q   <= mag_of(start_val);
            bcd_q   <= '0;
            step_q  <= '0;
            state_q <= CONV;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Glyph for the digit slot currently being scanned.
  always_comb begin
    case (idx_q)
      2'd0:    cur_glyph = disp0_q;
      2'd1:    cur_glyph = disp1_q;
      2'd2:    cur_glyph = disp2_q;
      default: cur_glyph = GL_BLANK;
    endcase
  end

  // Scan timer, digit index and registered anode/segment drivers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= AN_POL;
      seg_q <= SEG_POL;
    end else begin
      an_q  <= (4'b0001 << idx_q) ^ AN_POL;
      seg_q <= cur_glyph ^ SEG_POL;
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign busy = busy_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_calc_result_display.sv
// Bench for calc_result_display: directed vector table, hand sequences for
// back-to-back loads and mid-conversion reset, and random traffic checked
// against a value-level reference model.
module tb_calc_result_display;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] result = '0;
  logic       load = 1'b0;
  logic       busy;
  logic [3:0] an;
  logic [6:0] seg;

  calc_result_display #(
    .SCAN_DIV      (SD),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .result(result),
    .load  (load),
    .busy  (busy),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Lit-high glyphs for decimal digits.
  logic [6:0] GLYPH [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                             7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                             7'b1111111, 7'b1101111};

  // Reference model state: shown value, current/pending values, cycles left.
  int m_rem, m_cur, m_pend, m_pv, m_disp, m_cnt, m_idx;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_busy;
  logic [6:0] seen [4];

  typedef struct {
    logic [4:0] r;
    logic [6:0] g2, g1, g0;
  } vec_t;
  vec_t vecs [7];

  function automatic logic [6:0] render(int v, int d);
    int a;
    logic [6:0] lit;
    a = (v < 0) ? -v : v;
    lit = 7'b0;
    case (d)
      2: if (v < 0) lit = 7'b1000000;
      1: if (a >= 10) lit = GLYPH[a / 10];
      0: lit = GLYPH[a % 10];
      default: lit = 7'b0;
    endcase
    return ~lit;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_rem = 0; m_pv = 0; m_disp = 0; m_cnt = 0; m_idx = 0;
      e_an = 4'hF; e_seg = 7'h7F;
    end else begin
      e_an  = ~(4'b0001 << m_idx);
      e_seg = render(m_disp, m_idx);
      if (m_rem == 0) begin
        if (load) begin m_cur = $signed(result); m_rem = 6; end
      end else begin
        if (load) begin m_pend = $signed(result); m_pv = 1; end
        m_rem--;
        if (m_rem == 0) begin
          m_disp = m_cur;
          if (m_pv != 0) begin m_cur = m_pend; m_pv = 0; m_rem = 6; end
        end
      end
      m_cnt++;
      if (m_cnt == SD) begin m_cnt = 0; m_idx = (m_idx + 1) % 4; end
    end
    e_busy = (m_rem != 0);
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_an", {4'b0, an}, {4'b0, e_an});
    chk("model_seg", {1'b0, seg}, {1'b0, e_seg});
    chk("model_busy", {7'b0, busy}, {7'b0, e_busy});
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy && !e_busy) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk("idle_timeout", {7'b0, busy}, 8'd0);
  endtask

  task automatic capture();
    for (int k = 0; k < 4; k++) seen[k] = 7'bx;
    for (int i = 0; i < 4 * SD * 2; i++) begin
      tick();
      case (an)
        4'b1110: seen[0] = seg;
        4'b1101: seen[1] = seg;
        4'b1011: seen[2] = seg;
        4'b0111: seen[3] = seg;
        default: ;
      endcase
    end
  endtask

  task automatic check_digits(string tag, logic [6:0] g2, logic [6:0] g1, logic [6:0] g0);
    chk({tag, "_d3"}, {1'b0, seen[3]}, 8'h7F);
    chk({tag, "_d2"}, {1'b0, seen[2]}, {1'b0, g2});
    chk({tag, "_d1"}, {1'b0, seen[1]}, {1'b0, g1});
    chk({tag, "_d0"}, {1'b0, seen[0]}, {1'b0, g0});
  endtask

  initial begin
    int bcount;
    vecs[0] = '{5'b01111, 7'b1111111, 7'b1111001, 7'b0010010};
    vecs[1] = '{5'b10000, 7'b0111111, 7'b1111001, 7'b0000010};
    vecs[2] = '{5'b11111, 7'b0111111, 7'b1111111, 7'b1111001};
    vecs[3] = '{5'b00000, 7'b1111111, 7'b1111111, 7'b1000000};
    vecs[4] = '{5'b10111, 7'b0111111, 7'b1111111, 7'b0010000};
    vecs[5] = '{5'b01010, 7'b1111111, 7'b1111001, 7'b1000000};
    vecs[6] = '{5'b00111, 7'b1111111, 7'b1111111, 7'b1111000};

    // Reset state
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_an", {4'b0, an}, 8'h0F);
      chk("rst_seg", {1'b0, seg}, 8'h7F);
      chk("rst_busy", {7'b0, busy}, 8'd0);
    end
    // Scan walk after release
    rst_n = 1'b1;
    for (int i = 0; i < 4 * SD; i++) begin
      tick();
      chk("walk_an", {4'b0, an}, {4'b0, ~(4'b0001 << (i / SD))});
      chk("walk_seg", {1'b0, seg}, (i < SD) ? 8'b01000000 : 8'h7F);
    end

    // Vector table
    foreach (vecs[v]) begin
      wait_idle();
      result = vecs[v].r;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("busy_first", {7'b0, busy}, 8'd1);
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("busy_hold", {7'b0, busy}, 8'd1);
      end
      tick();
      chk("busy_drop", {7'b0, busy}, 8'd0);
      capture();
      check_digits("vec", vecs[v].g2, vecs[v].g1, vecs[v].g0);
    end

    // Back-to-back loads: +7 overwritten by +9
    wait_idle();
    bcount = 0;
    load = 1'b1;
    result = 5'd3; tick(); if (busy) bcount++;
    result = 5'd7; tick(); if (busy) bcount++;
    result = 5'd9; tick(); if (busy) bcount++;
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!busy) break;
      bcount++;
    end
    chk("b2b_busy_len", 8'(bcount), 8'd12);
    capture();
    check_digits("b2b", 7'b1111111, 7'b1111111, 7'b0010000);

    // Reset on the 3rd CONV cycle of a -9 conversion
    wait_idle();
    result = 5'b10111;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_an", {4'b0, an}, 8'h0F);
    chk("midrst_seg", {1'b0, seg}, 8'h7F);
    chk("midrst_busy", {7'b0, busy}, 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("midrst_idle", {7'b0, busy}, 8'd0);
    end
    capture();
    check_digits("midrst", 7'b1111111, 7'b1111111, 7'b1000000);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n  = ($urandom_range(0, 299) != 0);
      load   = ($urandom_range(0, 3) == 0);
      result = 5'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
